signed_spatial_mac_pipe: RTL and testbench
==========================================

Name: signed_spatial_mac_pipe

Overview:
- Pipelined, precision-fusible dot-product multiply-accumulate unit.
- Built from L_PRECISION-bit bricks. Each cycle it computes the sum of N signed/unsigned products, where N depends on the runtime operand precisions.
- Accumulates beats over a group and emits one result per group over a valid/ready stream.
- Sits between the operand buffers and the output/writeback logic of a PE.

Parameters:
PRECISION, 8, max operand precision in bits; power of 2, PRECISION/L_PRECISION <= 8
L_PRECISION, 2, brick precision in bits
IN_WIDTH, (PRECISION/L_PRECISION)*PRECISION, operand bus width
ACC_WIDTH, 32, accumulator and result width; must be >= 2*PRECISION+log2(IN_WIDTH/L_PRECISION)+1
SATURATE, 1, 1: clamp on overflow; 0: wrap

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
cfg_a_prec  in  2  A precision code k: p_a = L_PRECISION<<k; codes above log2(PRECISION/L_PRECISION) clamp to PRECISION
cfg_b_prec  in  2  B precision code, same encoding
cfg_a_signed  in  1  A elements are two's complement
cfg_b_signed  in  1  B elements are two's complement
in_valid  in  1  operand beat valid
in_ready  out  1  beat accepted when in_valid&in_ready
in_a  in  IN_WIDTH  packed A elements
in_b  in  IN_WIDTH  packed B elements
in_last  in  1  final beat of the accumulation group
out_valid  out  1  result valid
out_ready  in  1  result consumed when out_valid&out_ready
out_data  out  ACC_WIDTH  group result, two's complement if either operand signed, else unsigned
out_overflow  out  1  group overflowed, qualified by out_valid
busy  out  1  any pipeline stage valid or group partially accumulated

Behaviour:
- Element count and packing:
  - N = (PRECISION/p_a)*(PRECISION/p_b).
  - A element i = in_a[i*p_a +: p_a]; B element i = in_b[i*p_b +: p_b], for i < N.
  - Bits above N*p_a and N*p_b are ignored.
  - Beat value = sum of a_i*b_i. Each element is sign-extended if its operand is signed, zero-extended otherwise.
- Config sampling:
  - cfg_* are sampled on the first accepted beat of a group: the first beat after reset, or the first after a last beat.
  - The sampled config travels with every beat of that group. Changes to cfg_* mid-group are ignored.
- Pipeline (3 stages, shared enable adv = ~(out_valid & ~out_ready)):
  - S1 registers operands, config, last and valid.
  - S2 registers the beat dot product, width 2*PRECISION+log2(N_max)+1.
  - S3 adds into the accumulator.
- Output on last beat:
  - When S3 processes a last beat: out_data <= acc+beat (saturated or wrapped), out_overflow <= group sticky overflow OR this add's overflow, out_valid <= 1.
  - acc and sticky overflow clear to 0 on the same edge.
- Latency and throughput:
  - A last beat accepted in cycle 0 gives out_valid=1 in cycle 3 with no stall.
  - Back-to-back groups run with no bubbles; a single-beat group is legal.
- Handshake:
  - in_ready = adv, forced 0 while reset is asserted.
  - out_data, out_overflow and out_valid stay stable until out_ready.
  - When adv=0 every stage holds.
  - out_valid&out_ready with a new last beat in S3 on the same cycle: the new result replaces the old one, out_valid stays 1.
- Overflow and saturation:
  - The add is computed ACC_WIDTH+1 wide; overflow means the result is outside the ACC_WIDTH range (signed or unsigned per group).
  - SATURATE=1: clamp to 2^(ACC_WIDTH-1)-1 / -2^(ACC_WIDTH-1) when signed, or to 2^ACC_WIDTH-1 when unsigned.
  - SATURATE=0: wrap.
  - Overflow is flagged in both modes.
- Reset values:
  - All valids, acc, sticky overflow, out_data, out_overflow and out_valid reset to 0; busy=0.
  - Assertion mid-group discards all in-flight beats and the partial accumulation immediately, with no output.
- busy = S1|S2|S3 valid | group-open flag.

Test Plan:
- 8x8 signed, in_a=0x80, in_b=0x7F, last → cycle 3: out_data=0xFFFFC080 (-16256), out_overflow=0.
- 2x2, in_a=in_b=0xFFFFFFFF, last: unsigned → 144; both signed → 16; each result 3 cycles after its beat, back-to-back.
- p_a=8, p_b=2 (N=4), in_a=0x01020304, in_b=0xFF: b unsigned → 30; b signed → -10 (0xFFFFFFF6).
- 4-beat 4x4 unsigned group, each beat in_a=0x1234, in_b=0x1111 (beat=10), out_ready held low 5 cycles after result → out_data=40; in_ready=0 while out_valid&~out_ready; no beat lost; next group starts on release.
- ACC_WIDTH=16, SATURATE=1, 8x8 signed 127*127 x3 beats → out_data=0x7FFF, out_overflow=1; SATURATE=0 → 0xBD03, out_overflow=1.
- reset low during beat 2 of a 4-beat group → all outputs 0 immediately; after release, a fresh 1-beat group yields only its own product.

Source files
------------

// File: rtl/signed_spatial_mac_pipe_if.sv
// rtl/signed_spatial_mac_pipe_if.sv - operand beat and group result streams of the MAC pipe
interface signed_spatial_mac_pipe_if #(
    parameter int IN_WIDTH  = 32,
    parameter int ACC_WIDTH = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [IN_WIDTH-1:0]  in_a;
    logic [IN_WIDTH-1:0]  in_b;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out_data;
    logic                 out_overflow;

    modport master (
        output in_valid, in_a, in_b, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_overflow
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last, out_ready,
        output in_ready, out_valid, out_data, out_overflow
    );
endinterface

// File: rtl/signed_spatial_mac_pipe.sv
// rtl/signed_spatial_mac_pipe.sv - precision-fusible signed/unsigned dot-product MAC, 3-stage pipe
module signed_spatial_mac_pipe #(
    parameter int PRECISION   = 8,
    parameter int L_PRECISION = 2,
    parameter int IN_WIDTH    = (PRECISION / L_PRECISION) * PRECISION,
    parameter int ACC_WIDTH   = 32,
    parameter bit SATURATE    = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] cfg_a_prec_i,
    input  logic [1:0] cfg_b_prec_i,
    input  logic       cfg_a_signed_i,
    input  logic       cfg_b_signed_i,
    signed_spatial_mac_pipe_if.slave bus,
    output logic       busy_o
);
    localparam int RATIO  = PRECISION / L_PRECISION;
    localparam int N_MAX  = RATIO * RATIO;
    localparam int BEAT_W = 2 * PRECISION + $clog2(N_MAX) + 1;
    localparam int SUM_W  = ((ACC_WIDTH > BEAT_W) ? ACC_WIDTH : BEAT_W) + 2;
    localparam logic [1:0] K_MAX = 2'($clog2(RATIO));
    localparam logic signed [SUM_W-1:0] S_MAX = SUM_W'({1'b0, {(ACC_WIDTH-1){1'b1}}});
    localparam logic signed [SUM_W-1:0] S_MIN = ~S_MAX;
    localparam logic signed [SUM_W-1:0] U_MAX = SUM_W'({ACC_WIDTH{1'b1}});

    function automatic logic [1:0] clamp_prec(input logic [1:0] k);
        return (k > K_MAX) ? K_MAX : k;
    endfunction

    // element idx of a packed bus at brick-multiple width, extended to PRECISION+1 bits
    function automatic logic signed [PRECISION:0] get_elem(input logic [IN_WIDTH-1:0] vec,
                                                          input int idx, input logic [1:0] k,
                                                          input logic sgn);
        logic [IN_WIDTH-1:0] sh;
        logic [PRECISION:0]  mask;
        logic [PRECISION:0]  raw;
        int                  pw;
        pw   = L_PRECISION << k;
        sh   = vec >> (idx * pw);
        mask = (PRECISION+1)'((1 << pw) - 1);
        raw  = (PRECISION+1)'(sh) & mask;
        if (sgn && ((raw & (mask ^ (mask >> 1))) != '0)) raw = raw | ~mask;
        return $signed(raw);
    endfunction

    logic                        adv, accept;
    logic                        grp_open_q;
    logic [1:0]                  hold_a_prec_q, hold_b_prec_q;
    logic                        hold_a_sgn_q, hold_b_sgn_q;
    logic [1:0]                  a_prec_d, b_prec_d;
    logic                        a_sgn_d, b_sgn_d;
    logic                        s1_valid_q, s1_last_q, s1_a_sgn_q, s1_b_sgn_q;
    logic [1:0]                  s1_a_prec_q, s1_b_prec_q;
    logic [IN_WIDTH-1:0]         s1_a_q, s1_b_q;
    logic                        s2_valid_q, s2_last_q, s2_sgn_q;
    logic signed [BEAT_W-1:0]    s2_beat_q, dot;
    logic signed [PRECISION:0]   ea, eb;
    logic signed [2*PRECISION+1:0] prod;
    int                          n_elem;
    logic signed [SUM_W-1:0]     acc_ext, sum;
    logic                        add_ovf;
    logic [ACC_WIDTH-1:0]        sat_val, add_res;
    logic [ACC_WIDTH-1:0]        acc_q, acc_d, out_data_q, out_data_d;
    logic                        sticky_q, sticky_d, out_valid_q, out_valid_d, out_ovf_q, out_ovf_d;

    assign adv          = ~(out_valid_q & ~bus.out_ready);
    assign bus.in_ready = adv & rst_ni;
    assign accept       = bus.in_valid & bus.in_ready;

    // the first beat of a group samples cfg; later beats reuse the held copy
    always_comb begin
        a_prec_d = grp_open_q ? hold_a_prec_q : clamp_prec(cfg_a_prec_i);
        b_prec_d = grp_open_q ? hold_b_prec_q : clamp_prec(cfg_b_prec_i);
        a_sgn_d  = grp_open_q ? hold_a_sgn_q  : cfg_a_signed_i;
        b_sgn_d  = grp_open_q ? hold_b_sgn_q  : cfg_b_signed_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            grp_open_q    <= 1'b0;
            hold_a_prec_q <= '0;
            hold_b_prec_q <= '0;
            hold_a_sgn_q  <= 1'b0;
            hold_b_sgn_q  <= 1'b0;
            s1_valid_q    <= 1'b0;
            s1_last_q     <= 1'b0;
            s1_a_q        <= '0;
            s1_b_q        <= '0;
            s1_a_prec_q   <= '0;
            s1_b_prec_q   <= '0;
            s1_a_sgn_q    <= 1'b0;
            s1_b_sgn_q    <= 1'b0;
            s2_valid_q    <= 1'b0;
            s2_last_q     <= 1'b0;
            s2_sgn_q      <= 1'b0;
            s2_beat_q     <= '0;
        end else begin
            if (accept) begin
                grp_open_q    <= ~bus.in_last;
                hold_a_prec_q <= a_prec_d;
                hold_b_prec_q <= b_prec_d;
                hold_a_sgn_q  <= a_sgn_d;
                hold_b_sgn_q  <= b_sgn_d;
            end
            if (adv) begin
                s1_valid_q  <= accept;
                s1_last_q   <= bus.in_last;
                s1_a_q      <= bus.in_a;
                s1_b_q      <= bus.in_b;
                s1_a_prec_q <= a_prec_d;
                s1_b_prec_q <= b_prec_d;
                s1_a_sgn_q  <= a_sgn_d;
                s1_b_sgn_q  <= b_sgn_d;
                s2_valid_q  <= s1_valid_q;
                s2_last_q   <= s1_last_q;
                s2_sgn_q    <= s1_a_sgn_q | s1_b_sgn_q;
                s2_beat_q   <= dot;
            end
        end
    end

    always_comb begin
        dot    = '0;
        ea     = '0;
        eb     = '0;
        prod   = '0;
        n_elem = (RATIO >> s1_a_prec_q) * (RATIO >> s1_b_prec_q);
        for (int i = 0; i < N_MAX; i++) begin
            ea   = get_elem(s1_a_q, i, s1_a_prec_q, s1_a_sgn_q);
            eb   = get_elem(s1_b_q, i, s1_b_prec_q, s1_b_sgn_q);
            prod = ea * eb;
            if (i < n_elem) dot = dot + BEAT_W'(prod);
        end
    end

    // add is done wide enough that range checks against the ACC_WIDTH limits are exact
    always_comb begin
        acc_ext = s2_sgn_q ? SUM_W'($signed(acc_q)) : SUM_W'($signed({1'b0, acc_q}));
        sum     = acc_ext + SUM_W'(s2_beat_q);
        if (s2_sgn_q) begin
            add_ovf = (sum > S_MAX) || (sum < S_MIN);
            sat_val = (sum > S_MAX) ? S_MAX[ACC_WIDTH-1:0] : S_MIN[ACC_WIDTH-1:0];
        end else begin
            add_ovf = (sum > U_MAX) || sum[SUM_W-1];
            sat_val = sum[SUM_W-1] ? '0 : U_MAX[ACC_WIDTH-1:0];
        end
        add_res = (SATURATE && add_ovf) ? sat_val : sum[ACC_WIDTH-1:0];

        acc_d       = acc_q;
        sticky_d    = sticky_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        if (adv) begin
            out_valid_d = 1'b0;
            if (s2_valid_q && s2_last_q) begin
                out_valid_d = 1'b1;
                out_data_d  = add_res;
                out_ovf_d   = sticky_q | add_ovf;
                acc_d       = '0;
                sticky_d    = 1'b0;
            end else if (s2_valid_q) begin
                acc_d    = add_res;
                sticky_d = sticky_q | add_ovf;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q       <= '0;
            sticky_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            sticky_q    <= sticky_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign bus.out_valid    = out_valid_q;
    assign bus.out_data     = out_data_q;
    assign bus.out_overflow = out_ovf_q;
    assign busy_o           = s1_valid_q | s2_valid_q | out_valid_q | grp_open_q;
endmodule

// File: tb/tb_signed_spatial_mac_pipe.sv
// tb/tb_signed_spatial_mac_pipe.sv - directed vector bench for signed_spatial_mac_pipe
module tb_signed_spatial_mac_pipe;
    logic       clk;
    logic       rst_n;
    logic [1:0] cfg_ap, cfg_bp;
    logic       cfg_as, cfg_bs;
    logic       busy_m, busy_s, busy_w;
    int         checks;
    int         errors;

    signed_spatial_mac_pipe_if #(.IN_WIDTH(32), .ACC_WIDTH(32)) m_if ();
    signed_spatial_mac_pipe_if #(.IN_WIDTH(32), .ACC_WIDTH(16)) s_if ();
    signed_spatial_mac_pipe_if #(.IN_WIDTH(32), .ACC_WIDTH(16)) w_if ();

    signed_spatial_mac_pipe #(.PRECISION(8), .L_PRECISION(2), .IN_WIDTH(32),
                              .ACC_WIDTH(32), .SATURATE(1'b1)) dut_m (
        .clk_i(clk), .rst_ni(rst_n), .cfg_a_prec_i(cfg_ap), .cfg_b_prec_i(cfg_bp),
        .cfg_a_signed_i(cfg_as), .cfg_b_signed_i(cfg_bs), .bus(m_if.slave), .busy_o(busy_m));

    signed_spatial_mac_pipe #(.PRECISION(8), .L_PRECISION(2), .IN_WIDTH(32),
                              .ACC_WIDTH(16), .SATURATE(1'b1)) dut_s (
        .clk_i(clk), .rst_ni(rst_n), .cfg_a_prec_i(cfg_ap), .cfg_b_prec_i(cfg_bp),
        .cfg_a_signed_i(cfg_as), .cfg_b_signed_i(cfg_bs), .bus(s_if.slave), .busy_o(busy_s));

    signed_spatial_mac_pipe #(.PRECISION(8), .L_PRECISION(2), .IN_WIDTH(32),
                              .ACC_WIDTH(16), .SATURATE(1'b0)) dut_w (
        .clk_i(clk), .rst_ni(rst_n), .cfg_a_prec_i(cfg_ap), .cfg_b_prec_i(cfg_bp),
        .cfg_a_signed_i(cfg_as), .cfg_b_signed_i(cfg_bs), .bus(w_if.slave), .busy_o(busy_w));

    typedef struct {
        logic [1:0]  ap;
        logic [1:0]  bp;
        logic        as_;
        logic        bs_;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_data;
        logic        exp_ovf;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_out_m(input string name);
        int n;
        n = 0;
        while (!m_if.out_valid && n < 10) begin
            step();
            n++;
        end
        check({name, "_valid"}, 32'(m_if.out_valid), 32'd1);
    endtask

    task automatic set_cfg(input logic [1:0] ap, input logic [1:0] bp, input logic as_, input logic bs_);
        cfg_ap = ap;
        cfg_bp = bp;
        cfg_as = as_;
        cfg_bs = bs_;
    endtask

    task automatic drive_m(input logic v, input logic [31:0] a, input logic [31:0] b, input logic last);
        m_if.in_valid = v;
        m_if.in_a     = a;
        m_if.in_b     = b;
        m_if.in_last  = last;
    endtask

    task automatic drive_16(input logic v, input logic [31:0] a, input logic [31:0] b, input logic last);
        s_if.in_valid = v;
        s_if.in_a     = a;
        s_if.in_b     = b;
        s_if.in_last  = last;
        w_if.in_valid = v;
        w_if.in_a     = a;
        w_if.in_b     = b;
        w_if.in_last  = last;
    endtask

    initial begin
        int n;
        checks = 0;
        errors = 0;
        vecs[0]  = '{2'd2, 2'd2, 1'b1, 1'b1, 32'h80,       32'h7F,       32'hFFFFC080, 1'b0};
        vecs[1]  = '{2'd0, 2'd0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd144,      1'b0};
        vecs[2]  = '{2'd0, 2'd0, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd16,       1'b0};
        vecs[3]  = '{2'd2, 2'd0, 1'b0, 1'b0, 32'h01020304, 32'hFF,       32'd30,       1'b0};
        vecs[4]  = '{2'd2, 2'd0, 1'b0, 1'b1, 32'h01020304, 32'hFF,       32'hFFFFFFF6, 1'b0};
        vecs[5]  = '{2'd1, 2'd1, 1'b0, 1'b0, 32'h1234,     32'h1111,     32'd10,       1'b0};
        vecs[6]  = '{2'd3, 2'd3, 1'b1, 1'b1, 32'hFF,       32'h02,       32'hFFFFFFFE, 1'b0};
        vecs[7]  = '{2'd2, 2'd2, 1'b0, 1'b0, 32'hFF,       32'hFF,       32'h0000FE01, 1'b0};
        vecs[8]  = '{2'd2, 2'd2, 1'b0, 1'b1, 32'hFF,       32'hFF,       32'hFFFFFF01, 1'b0};
        vecs[9]  = '{2'd1, 2'd1, 1'b0, 1'b0, 32'hABCD1234, 32'h99991111, 32'd10,       1'b0};
        vecs[10] = '{2'd0, 2'd2, 1'b1, 1'b0, 32'h1B,       32'h04030201, 32'hFFFFFFFE, 1'b0};

        rst_n = 1'b0;
        set_cfg(2'd0, 2'd0, 1'b0, 1'b0);
        drive_m(1'b0, '0, '0, 1'b0);
        drive_16(1'b0, '0, '0, 1'b0);
        m_if.out_ready = 1'b1;
        s_if.out_ready = 1'b1;
        w_if.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(m_if.in_ready), 32'd0);
        check("rst_out_valid", 32'(m_if.out_valid), 32'd0);
        check("rst_out_data", m_if.out_data, 32'd0);
        check("rst_out_ovf", 32'(m_if.out_overflow), 32'd0);
        check("rst_busy", 32'(busy_m), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // back-to-back single-beat groups, one result per cycle three cycles later
        for (int t = 0; t < NV + 2; t++) begin
            if (t < NV) begin
                set_cfg(vecs[t].ap, vecs[t].bp, vecs[t].as_, vecs[t].bs_);
                drive_m(1'b1, vecs[t].a, vecs[t].b, 1'b1);
            end else begin
                drive_m(1'b0, '0, '0, 1'b0);
            end
            step();
            if (t >= 2) begin
                check($sformatf("vec%0d_valid", t - 2), 32'(m_if.out_valid), 32'd1);
                check($sformatf("vec%0d_data", t - 2), m_if.out_data, vecs[t-2].exp_data);
                check($sformatf("vec%0d_ovf", t - 2), 32'(m_if.out_overflow), 32'(vecs[t-2].exp_ovf));
            end else begin
                check($sformatf("latency_t%0d", t), 32'(m_if.out_valid), 32'd0);
            end
        end
        step();
        check("drain_valid", 32'(m_if.out_valid), 32'd0);

        // 4-beat group, cfg changed mid-group, result held under back-pressure
        m_if.out_ready = 1'b0;
        set_cfg(2'd1, 2'd1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            drive_m(1'b1, 32'h1234, 32'h1111, k == 3);
            step();
            set_cfg(2'd2, 2'd2, 1'b1, 1'b1);
        end
        drive_m(1'b0, '0, '0, 1'b0);
        wait_out_m("grp4");
        check("grp4_data", m_if.out_data, 32'd40);
        check("grp4_ovf", 32'(m_if.out_overflow), 32'd0);
        drive_m(1'b1, 32'h03, 32'h05, 1'b1);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("stall%0d_in_ready", k), 32'(m_if.in_ready), 32'd0);
            check($sformatf("stall%0d_valid", k), 32'(m_if.out_valid), 32'd1);
            check($sformatf("stall%0d_data", k), m_if.out_data, 32'd40);
            step();
        end
        m_if.out_ready = 1'b1;
        #1;
        check("release_in_ready", 32'(m_if.in_ready), 32'd1);
        step();
        drive_m(1'b0, '0, '0, 1'b0);
        check("release_consumed", 32'(m_if.out_valid), 32'd0);
        wait_out_m("after_stall");
        check("after_stall_data", m_if.out_data, 32'd15);
        step();

        // ACC_WIDTH=16 saturating vs wrapping, 3 beats of 127*127
        set_cfg(2'd2, 2'd2, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            drive_16(1'b1, 32'h7F, 32'h7F, k == 2);
            step();
        end
        drive_16(1'b0, '0, '0, 1'b0);
        n = 0;
        while (!s_if.out_valid && n < 10) begin
            step();
            n++;
        end
        check("sat_valid", 32'(s_if.out_valid), 32'd1);
        check("sat_data", 32'(s_if.out_data), 32'h7FFF);
        check("sat_ovf", 32'(s_if.out_overflow), 32'd1);
        check("wrap_valid", 32'(w_if.out_valid), 32'd1);
        check("wrap_data", 32'(w_if.out_data), 32'hBD03);
        check("wrap_ovf", 32'(w_if.out_overflow), 32'd1);
        step();

        // reset asserted while beat 2 of a 4-beat group is on the bus
        set_cfg(2'd1, 2'd1, 1'b0, 1'b0);
        drive_m(1'b1, 32'h1234, 32'h1111, 1'b0);
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(m_if.out_valid), 32'd0);
        check("midrst_data", m_if.out_data, 32'd0);
        check("midrst_ovf", 32'(m_if.out_overflow), 32'd0);
        check("midrst_busy", 32'(busy_m), 32'd0);
        check("midrst_in_ready", 32'(m_if.in_ready), 32'd0);
        check("midrst_sat_data", 32'(s_if.out_data), 32'd0);
        drive_m(1'b0, '0, '0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        set_cfg(2'd2, 2'd2, 1'b0, 1'b0);
        drive_m(1'b1, 32'h17, 32'h06, 1'b1);
        step();
        drive_m(1'b0, '0, '0, 1'b0);
        wait_out_m("fresh");
        check("fresh_data", m_if.out_data, 32'd138);
        check("fresh_ovf", 32'(m_if.out_overflow), 32'd0);
        step();
        check("idle_busy", 32'(busy_m), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
